// File: rtl/demod_deframer.sv
// demod_deframer: recovers bits from an oversampled demodulator stream,
// hunts for the 8'hA5 sync word, then deframes 8-bit LSB-first bytes each
// followed by a stop bit.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rst        - synchronous active-high reset (wins over ena)
//   ena        - clock enable; low freezes all state and suppresses strobes
//   sel[1:0]   - oversampling: 00=4, 01=8, 10=16, 11=32 clocks per bit
//   demod_in   - asynchronous demodulated serial bit stream
//   data_out   - last byte received with a good stop bit
//   data_valid - one-cycle strobe marking a new data_out
//   locked     - high from sync-word detection until a bad stop bit
//   frame_err  - one-cycle strobe on a bad stop bit
module demod_deframer (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [1:0] sel,
   input  logic       demod_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       locked,
   output logic       frame_err
);

   localparam int unsigned PH_W   = 5;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam logic [BYTE_W-1:0] SYNC_WORD = 8'hA5;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t              state_q;
   logic                sync1_q;
   logic                sync2_q;
   logic                s_prev_q;
   logic [PH_W-1:0]     phase_q;
   logic [1:0]          sel_lat_q;
   logic [BYTE_W-1:0]   hunt_q;
   logic [BYTE_W-1:0]   byte_q;
   logic [IDX_W-1:0]    bit_idx_q;
   logic [BYTE_W-1:0]   data_out_q;
   logic                data_valid_q;
   logic                locked_q;
   logic                frame_err_q;

   logic [1:0]          eff_sel;
   logic [PH_W-1:0]     n_max;
   logic [PH_W-1:0]     n_half;
   logic                edge_det;
   logic                take_bit;
   logic [PH_W-1:0]     phase_d;
   logic [BYTE_W-1:0]   hunt_d;

   // Oversampling ratio: live from sel while hunting, latched once framed.
   always_comb begin
      eff_sel = (state_q == HUNT) ? sel : sel_lat_q;
      n_max   = 5'd3;
      n_half  = 5'd2;
      case (eff_sel)
         2'b00: begin n_max = 5'd3;  n_half = 5'd2;  end
         2'b01: begin n_max = 5'd7;  n_half = 5'd4;  end
         2'b10: begin n_max = 5'd15; n_half = 5'd8;  end
         2'b11: begin n_max = 5'd31; n_half = 5'd16; end
         default: begin n_max = 5'd3; n_half = 5'd2; end
      endcase
   end

   // Edge re-centres the bit clock; an edge cycle never yields a bit. The
   // >= compare also folds a phase left over from a larger N back to 0.
   always_comb begin
      edge_det = sync2_q ^ s_prev_q;
      take_bit = !edge_det && (phase_q == n_half);
      if (edge_det) begin
         phase_d = 5'd1;
      end else if (phase_q >= n_max) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + 5'd1;
      end
      hunt_d = {hunt_q[BYTE_W-2:0], sync2_q};
   end

   // Synchronizer, bit clock and framing state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         s_prev_q     <= 1'b0;
         phase_q      <= '0;
         sel_lat_q    <= '0;
         hunt_q       <= '0;
         byte_q       <= '0;
         bit_idx_q    <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (ena) begin
            sync1_q  <= demod_in;
            sync2_q  <= sync1_q;
            s_prev_q <= sync2_q;
            phase_q  <= phase_d;
            if (state_q == HUNT) begin
               sel_lat_q <= sel;
            end
            if (take_bit) begin
               case (state_q)
                  HUNT: begin
                     hunt_q <= hunt_d;
                     if (hunt_d == SYNC_WORD) begin
                        state_q   <= DATA;
                        locked_q  <= 1'b1;
                        bit_idx_q <= '0;
                     end
                  end
                  DATA: begin
                     byte_q[bit_idx_q] <= sync2_q;
                     bit_idx_q         <= bit_idx_q + 3'd1;
                     if (bit_idx_q == 3'd7) begin
                        state_q <= STOP;
                     end
                  end
                  STOP: begin
                     if (sync2_q) begin
                        data_out_q   <= byte_q;
                        data_valid_q <= 1'b1;
                        bit_idx_q    <= '0;
                        state_q      <= DATA;
                     end else begin
                        frame_err_q <= 1'b1;
                        locked_q    <= 1'b0;
                        hunt_q      <= '0;
                        state_q     <= HUNT;
                     end
                  end
                  default: state_q <= HUNT;
               endcase
            end
         end
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign locked     = locked_q;
   assign frame_err  = frame_err_q;

endmodule
